// File: rtl/axis_cic_decim.sv
`default_nettype none
// ============================================================================
// Module   : axis_cic_decim
// Purpose  : Reconstructs signed multi-bit samples from a 1-bit sigma-delta
//            AXI-Stream bitstream. An ORDER-stage CIC decimator divides the
//            rate by DECIM = 2**LOG2_DECIM.
// Ports    : aclk, arst_n          clock, asynchronous active-low reset
//            s_axis_data_*         1-bit input stream (1 -> +1, 0 -> -1)
//            m_axis_data_*         WIDTH-bit signed output stream
//            m_axis_data_tlast     frame end; present only when the macro
//                                  AXIS_CIC_DECIM_TLAST_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
module axis_cic_decim #(
  parameter int WIDTH      = 16,
  parameter int ORDER      = 2,
  parameter int LOG2_DECIM = 8,
  parameter int FRAME_LEN  = 256
) (
  input  logic             aclk,
  input  logic             arst_n,
  input  logic             s_axis_data_tdata,
  input  logic             s_axis_data_tvalid,
  output logic             s_axis_data_tready,
  output logic [WIDTH-1:0] m_axis_data_tdata,
  output logic             m_axis_data_tvalid,
  input  logic             m_axis_data_tready
`ifdef AXIS_CIC_DECIM_TLAST_EN
  ,
  output logic             m_axis_data_tlast
`endif
);

  localparam int ACC_W = ORDER * LOG2_DECIM + 2;
  localparam int SHIFT = ORDER * LOG2_DECIM - (WIDTH - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // Elaboration-time legality checks on the parameter set.
  if (ORDER < 1 || ORDER > 4) begin : g_bad_order
    $error("axis_cic_decim: ORDER must be 1..4");
  end
  if (SHIFT < 0) begin : g_bad_decim
    $error("axis_cic_decim: ORDER*LOG2_DECIM must be >= WIDTH-1");
  end
  if (FRAME_LEN < 1) begin : g_bad_frame
    $error("axis_cic_decim: FRAME_LEN must be >= 1");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [ORDER-1:0][ACC_W-1:0] integ_q, integ_d;
  logic [ORDER-1:0][ACC_W-1:0] comb_dly_q, comb_dly_d;
  logic [LOG2_DECIM-1:0]       dcnt_q, dcnt_d;
  logic                        tvalid_q, tvalid_d;
  logic [WIDTH-1:0]            tdata_q, tdata_d;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic xfer;
  logic dec_evt;
  logic [ACC_W-1:0] x_ext;

  assign s_axis_data_tready = ~tvalid_q | m_axis_data_tready;
  assign xfer    = s_axis_data_tvalid & s_axis_data_tready;
  assign dec_evt = xfer & (&dcnt_q);
  // +1 or -1 in ACC_W-bit two's complement.
  assign x_ext   = s_axis_data_tdata ? ACC_W'(1) : {ACC_W{1'b1}};

  // --------------------------------------------------------------------------
  // Integrators: each stage adds the previous stage's current (old) value,
  // so all stages advance together on one accepted beat. Wrap is intended.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < ORDER; k++) begin : g_integ
    if (k == 0) begin : g_first
      assign integ_d[k] = integ_q[k] + x_ext;
    end else begin : g_rest
      assign integ_d[k] = integ_q[k] + integ_q[k-1];
    end
  end

  // --------------------------------------------------------------------------
  // Comb chain: fed by the next-state last integrator so the sample includes
  // the event beat. comb_w[k] is the input of comb stage k.
  // --------------------------------------------------------------------------
  logic [ORDER:0][ACC_W-1:0] comb_w;
  assign comb_w[0] = integ_d[ORDER-1];
  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    assign comb_w[k+1] = comb_w[k] - comb_dly_q[k];
  end

  // --------------------------------------------------------------------------
  // Scale and saturate
  // --------------------------------------------------------------------------
  logic signed [ACC_W-1:0] scaled;
  logic [WIDTH-1:0]        sat;

  assign scaled = $signed(comb_w[ORDER]) >>> SHIFT;

  always_comb begin
    sat = scaled[WIDTH-1:0];
    if (scaled > SAT_MAX) begin
      sat = SAT_MAX[WIDTH-1:0];
    end else if (scaled < SAT_MIN) begin
      sat = SAT_MIN[WIDTH-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    dcnt_d     = dcnt_q;
    comb_dly_d = comb_dly_q;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    if (xfer) begin
      dcnt_d = dcnt_q + 1'b1;
    end
    if (dec_evt) begin
      comb_dly_d = comb_w[ORDER-1:0];
      tvalid_d   = 1'b1;
      tdata_d    = sat;
    end else if (m_axis_data_tready) begin
      tvalid_d   = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      integ_q    <= '0;
      comb_dly_q <= '0;
      dcnt_q     <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
    end else begin
      if (xfer) begin
        integ_q <= integ_d;
      end
      dcnt_q     <= dcnt_d;
      comb_dly_q <= comb_dly_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
    end
  end

  assign m_axis_data_tvalid = tvalid_q;
  assign m_axis_data_tdata  = tdata_q;

`ifdef AXIS_CIC_DECIM_TLAST_EN
  // --------------------------------------------------------------------------
  // Frame counter: index of the sample currently held in the output register.
  // It only moves on a handshake, so tlast stays stable with tdata.
  // --------------------------------------------------------------------------
  localparam int FRM_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_LEN - 1);

  logic [FRM_W-1:0] frame_q, frame_d;
  logic             out_hs;

  assign out_hs = tvalid_q & m_axis_data_tready;

  always_comb begin
    frame_d = frame_q;
    if (out_hs) begin
      frame_d = (frame_q == FRM_LAST) ? '0 : frame_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign m_axis_data_tlast = tvalid_q & (frame_q == FRM_LAST);
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_cic_decim.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_cic_decim
// Purpose  : Self-checking bench for axis_cic_decim at default parameters.
//            Expected samples come from a closed-form CIC reference: the
//            second-order integrator value after n beats is a weighted sum
//            of all inputs, and each output is its second difference taken
//            at multiples of the decimation ratio, then scaled and clipped.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_cic_decim;

  localparam int WIDTH = 16;
  localparam int DECIM = 256;

  logic             aclk = 1'b0;
  logic             arst_n = 1'b0;
  logic             s_bit = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
`ifdef AXIS_CIC_DECIM_TLAST_EN
  logic             m_last;
`endif

  axis_cic_decim dut (
    .aclk               (aclk),
    .arst_n             (arst_n),
    .s_axis_data_tdata  (s_bit),
    .s_axis_data_tvalid (s_valid),
    .s_axis_data_tready (s_ready),
    .m_axis_data_tdata  (m_data),
    .m_axis_data_tvalid (m_valid),
    .m_axis_data_tready (m_ready)
`ifdef AXIS_CIC_DECIM_TLAST_EN
    ,
    .m_axis_data_tlast  (m_last)
`endif
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          bq[$];          // accepted inputs as +1/-1 since reset
  int          nbeats = 0;
  int          hs = 0;         // output handshakes since reset
  logic [15:0] ycache[int];
  bit          steady_on = 1'b0;
  logic [15:0] steady_exp = '0;

  // Integrator-2 value after n beats: sum of x[i] * (n-1-i) over i < n-1.
  function automatic longint vat(int n);
    longint s = 0;
    for (int i = 0; i < n - 1; i++) s += longint'(bq[i]) * longint'(n - 1 - i);
    return s;
  endfunction

  function automatic logic [15:0] model(int k);
    longint c, y;
    logic [63:0] yb;
    c = vat(DECIM * k) - 2 * ((k >= 2) ? vat(DECIM * (k - 1)) : 64'sd0)
        + ((k >= 3) ? vat(DECIM * (k - 2)) : 64'sd0);
    y = c >>> 1;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    yb = y;
    return yb[15:0];
  endfunction

  function automatic logic [15:0] expect_sample(int k);
    if (!ycache.exists(k)) ycache[k] = model(k);
    return ycache[k];
  endfunction

  // One clock of stimulus; outputs are checked half a cycle from the edge.
  task automatic cyc(input logic v, input logic b, input logic r);
    logic        ev;
    logic [15:0] ed;
    @(negedge aclk);
    s_valid = v;
    s_bit   = b;
    m_ready = r;
    #1;
    ev = ((nbeats / DECIM) > hs);
    total++;
    assert (m_valid === ev) else begin
      bad++;
      $error("FAIL tvalid obs=%0b exp=%0b beats=%0d hs=%0d", m_valid, ev, nbeats, hs);
    end
    total++;
    assert (s_ready === (~ev | r)) else begin
      bad++;
      $error("FAIL s_tready obs=%0b exp=%0b", s_ready, ~ev | r);
    end
    if (ev) begin
      ed = expect_sample(hs + 1);
      total++;
      assert (m_data === ed) else begin
        bad++;
        $error("FAIL tdata idx=%0d obs=%0d exp=%0d", hs + 1, $signed(m_data), $signed(ed));
      end
`ifdef AXIS_CIC_DECIM_TLAST_EN
      total++;
      assert (m_last === ((hs % 256) == 255)) else begin
        bad++;
        $error("FAIL tlast idx=%0d obs=%0b exp=%0b", hs + 1, m_last, (hs % 256) == 255);
      end
`endif
      if (r) begin
        if (steady_on && hs >= 2) begin
          total++;
          assert (m_data === steady_exp) else begin
            bad++;
            $error("FAIL steady idx=%0d obs=%0d exp=%0d", hs + 1, $signed(m_data),
                   $signed(steady_exp));
          end
        end
        hs++;
      end
    end
    if (v && (~ev | r)) begin
      bq.push_back(b ? 1 : -1);
      nbeats++;
    end
  endtask

  task automatic clear_model();
    bq.delete();
    ycache.delete();
    nbeats = 0;
    hs     = 0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    @(negedge aclk);
    #2;
    arst_n = 1'b0;
    #1;
    total++;
    assert (m_valid === 1'b0) else begin
      bad++;
      $error("FAIL rst_tvalid obs=%0b exp=0", m_valid);
    end
    total++;
    assert (m_data === 16'h0000) else begin
      bad++;
      $error("FAIL rst_tdata obs=%0h exp=0", m_data);
    end
    total++;
    assert (s_ready === 1'b1) else begin
      bad++;
      $error("FAIL rst_tready obs=%0b exp=1", s_ready);
    end
    clear_model();
    @(negedge aclk);
    @(negedge aclk);
    arst_n = 1'b1;
  endtask

  task automatic flush();
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // Power-on reset
    do_reset();

    // All ones: saturates at full positive scale
    steady_on = 1'b1; steady_exp = 16'sd32767;
    for (int i = 0; i < DECIM * 6; i++) cyc(1'b1, 1'b1, 1'b1);
    flush();

    // All zeros: full negative scale
    do_reset();
    steady_exp = 16'h8000;
    for (int i = 0; i < DECIM * 6; i++) cyc(1'b1, 1'b0, 1'b1);
    flush();

    // Alternating 1,0: zero mean
    do_reset();
    steady_exp = 16'h0000;
    for (int i = 0; i < DECIM * 6; i++) cyc(1'b1, (i % 2) == 0, 1'b1);
    flush();

    // Repeating 1,1,1,0: mean one half
    do_reset();
    steady_exp = 16'sd16384;
    for (int i = 0; i < DECIM * 6; i++) cyc(1'b1, (i % 4) != 3, 1'b1);
    flush();

    // Ones with the sink stalled for three sample periods
    do_reset();
    steady_exp = 16'sd32767;
    for (int i = 0; i < DECIM * 2 + 10; i++) cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < DECIM * 3; i++)      cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < DECIM * 4; i++)      cyc(1'b1, 1'b1, 1'b1);
    flush();

    // Random bits, random valid and ready
    do_reset();
    steady_on = 1'b0;
    for (int i = 0; i < DECIM * 10; i++)
      cyc(($urandom % 4) != 0, 1'($urandom), ($urandom % 3) != 0);
    flush();

    // Reset in the middle of a frame while valid toggles randomly
    for (int i = 0; i < DECIM * 2 + 100; i++)
      cyc(1'($urandom), 1'($urandom), 1'b1);
    do_reset();
    for (int i = 0; i < DECIM * 4; i++)
      cyc(1'($urandom), 1'($urandom), 1'b1);
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
